// File: rtl/bet_settlement_if.sv
// Bet/outcome/change signal bundle between the betting front end and bet_settlement.
// The slave side is the settlement block; the master side drives bets and consumes changes.
interface bet_settlement_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] balance;
  logic [WIDTH-1:0] bet_amount;
  logic             place_bet;
  logic             bet_cancel;
  logic             outcome_valid;
  logic [1:0]       outcome;
  logic             change_ack;
  logic [WIDTH-1:0] currency_change;
  logic             change_sign;
  logic             change_valid;
  logic             bet_locked;
  logic             bet_reject;
  logic [1:0]       state;

  modport master (
    output balance, bet_amount, place_bet, bet_cancel, outcome_valid, outcome, change_ack,
    input  currency_change, change_sign, change_valid, bet_locked, bet_reject, state
  );

  modport slave (
    input  balance, bet_amount, place_bet, bet_cancel, outcome_valid, outcome, change_ack,
    output currency_change, change_sign, change_valid, bet_locked, bet_reject, state
  );
endinterface

// File: rtl/bet_settlement.sv
// Validates and holds one bet per round, turns the round outcome into a signed
// change (magnitude + sign) and presents it to the currency updater until acked.
module bet_settlement #(
  parameter int WIDTH   = 8,
  parameter int MIN_BET = 1
) (
  input logic              clk,
  input logic              resetn,
  bet_settlement_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HELD    = 2'b01,
    SETTLE  = 2'b10,
    PRESENT = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_BET);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] bet_reg, bet_next;
  logic [1:0]       outcome_reg, outcome_next;
  logic [WIDTH-1:0] change_reg, change_next;
  logic             sign_reg, sign_next;
  logic             reject_reg, reject_next;

  logic             bet_ok;
  logic [WIDTH:0]   bj_sum;
  logic [WIDTH-1:0] bj_change;

  assign bet_ok = (bus.bet_amount >= MIN_W) && (bus.bet_amount <= bus.balance);

  // Blackjack pays 3:2 (floored); the extra bit catches overflow for saturation.
  assign bj_sum    = {1'b0, bet_reg} + {2'b00, bet_reg[WIDTH-1:1]};
  assign bj_change = bj_sum[WIDTH] ? {WIDTH{1'b1}} : bj_sum[WIDTH-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      bet_reg     <= '0;
      outcome_reg <= '0;
      change_reg  <= '0;
      sign_reg    <= 1'b0;
      reject_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bet_reg     <= bet_next;
      outcome_reg <= outcome_next;
      change_reg  <= change_next;
      sign_reg    <= sign_next;
      reject_reg  <= reject_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bet_next     = bet_reg;
    outcome_next = outcome_reg;
    change_next  = change_reg;
    sign_next    = sign_reg;
    reject_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.place_bet) begin
          if (bet_ok) begin
            bet_next   = bus.bet_amount;
            state_next = HELD;
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      HELD: begin
        // An outcome arriving with a cancel still settles the round.
        if (bus.outcome_valid) begin
          outcome_next = bus.outcome;
          state_next   = SETTLE;
        end else if (bus.bet_cancel) begin
          state_next = IDLE;
        end
      end
      SETTLE: begin
        case (outcome_reg)
          2'b00:   begin change_next = bet_reg;   sign_next = 1'b1; end
          2'b01:   begin change_next = '0;        sign_next = 1'b0; end
          2'b10:   begin change_next = bet_reg;   sign_next = 1'b0; end
          default: begin change_next = bj_change; sign_next = 1'b0; end
        endcase
        state_next = PRESENT;
      end
      PRESENT: begin
        if (bus.change_ack) begin
          change_next = '0;
          sign_next   = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.currency_change = change_reg;
    bus.change_sign     = sign_reg;
    bus.change_valid    = (state_reg == PRESENT);
    bus.bet_locked      = (state_reg != IDLE);
    bus.bet_reject      = reject_reg;
    bus.state           = state_reg;
  end
endmodule
